// File: rtl/reset_sequencer.sv
// Sequences the debug and system resets from a synchronised clock-manager lock,
// with a CPU-requested soft reset of the system domain and a saturating lock-loss counter.
module reset_sequencer #(
    parameter int LOCK_STABLE_CYCLES = 16,
    parameter int SEQ_GAP            = 4,
    parameter int RST_HOLD_CYCLES    = 8,
    parameter int CNT_W              = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             locked,
    input  logic             sw_rst_req,
    output logic             rst_sys,
    output logic             rst_dbg,
    output logic             ready,
    output logic [CNT_W-1:0] lock_loss_cnt
);

    typedef enum logic [2:0] {
        S_WAIT,
        S_STABLE,
        S_DBG_REL,
        S_RUN,
        S_SOFT
    } state_t;

    // The shared counter only has to reach the longest residence minus one.
    localparam int MAX_AB = (LOCK_STABLE_CYCLES > SEQ_GAP) ? LOCK_STABLE_CYCLES : SEQ_GAP;
    localparam int MAX_C  = (MAX_AB > RST_HOLD_CYCLES) ? MAX_AB : RST_HOLD_CYCLES;
    localparam int CW     = (MAX_C > 1) ? $clog2(MAX_C) : 1;

    localparam logic [CW-1:0]    STABLE_LAST = CW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CW-1:0]    GAP_LAST    = CW'(SEQ_GAP - 1);
    localparam logic [CW-1:0]    HOLD_LAST   = CW'(RST_HOLD_CYCLES - 1);
    localparam logic [CW-1:0]    CNT_ONE     = CW'(1);
    localparam logic [CNT_W-1:0] LOSS_ONE    = CNT_W'(1);

    logic          sync1_reg;
    logic          locked_s;
    state_t        state_reg;
    state_t        state_next;
    logic [CW-1:0] cnt_reg;
    logic [CW-1:0] cnt_next;
    logic          lock_fall;

    // locked_s is about to drop on this edge, so the count moves together with it.
    assign lock_fall = locked_s & ~sync1_reg;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg + CNT_ONE;
        case (state_reg)
            S_WAIT: begin
                cnt_next = '0;
                if (locked_s)
                    state_next = S_STABLE;
            end
            S_STABLE: begin
                if (!locked_s)
                    state_next = S_WAIT;
                else if (cnt_reg == STABLE_LAST)
                    state_next = S_DBG_REL;
            end
            S_DBG_REL: begin
                if (!locked_s)
                    state_next = S_WAIT;
                else if (cnt_reg == GAP_LAST)
                    state_next = S_RUN;
            end
            S_RUN: begin
                cnt_next = '0;
                if (!locked_s)
                    state_next = S_WAIT;
                else if (sw_rst_req)
                    state_next = S_SOFT;
            end
            S_SOFT: begin
                if (!locked_s)
                    state_next = S_WAIT;
                else if (cnt_reg == HOLD_LAST)
                    state_next = S_RUN;
            end
            default: begin
                state_next = S_WAIT;
            end
        endcase
        if (state_next != state_reg)
            cnt_next = '0;
    end

    // Outputs decode state_next so they switch on the same edge as the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_reg     <= 1'b0;
            locked_s      <= 1'b0;
            state_reg     <= S_WAIT;
            cnt_reg       <= '0;
            rst_sys       <= 1'b1;
            rst_dbg       <= 1'b1;
            ready         <= 1'b0;
            lock_loss_cnt <= '0;
        end else begin
            sync1_reg <= locked;
            locked_s  <= sync1_reg;
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            rst_dbg   <= !((state_next == S_DBG_REL) || (state_next == S_RUN) ||
                           (state_next == S_SOFT));
            rst_sys   <= (state_next != S_RUN);
            ready     <= (state_next == S_RUN);
            if (lock_fall && !(&lock_loss_cnt))
                lock_loss_cnt <= lock_loss_cnt + LOSS_ONE;
        end
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench for reset_sequencer: stimulus queues the expected outputs for
// given clock edges, and a negedge monitor pops and compares them as those edges arrive.
module tb_reset_sequencer;

    logic       clk;
    logic       srst;
    logic       locked;
    logic       sw_rst_req;
    logic       rst_sys;
    logic       rst_dbg;
    logic       ready;
    logic [7:0] lock_loss_cnt;

    reset_sequencer #(
        .LOCK_STABLE_CYCLES(16),
        .SEQ_GAP           (4),
        .RST_HOLD_CYCLES   (8),
        .CNT_W             (8)
    ) dut (
        .clk          (clk),
        .reset        (srst),
        .locked       (locked),
        .sw_rst_req   (sw_rst_req),
        .rst_sys      (rst_sys),
        .rst_dbg      (rst_dbg),
        .ready        (ready),
        .lock_loss_cnt(lock_loss_cnt)
    );

    typedef struct {
        int    cyc;
        logic  sys;
        logic  dbg;
        logic  rdy;
        int    llc;
        string name;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   end_req = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic expect_at(input int e, input logic s, input logic d, input logic r,
                             input int l, input string n);
        exp_t x;
        x.cyc = e; x.sys = s; x.dbg = d; x.rdy = r; x.llc = l; x.name = n;
        sb.push_back(x);
    endtask

    // Returns just after edge e, so inputs driven now are sampled at edge e+1.
    task automatic goto(input int e);
        while (cyc < e) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: compares every queued expectation whose edge has come.
    always @(negedge clk) begin
        exp_t x;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            x = sb.pop_front();
            checks++;
            if (x.cyc != cyc) begin
                errors++;
                $display("FAIL %s: expectation for edge %0d not checked until edge %0d",
                         x.name, x.cyc, cyc);
            end else if (rst_sys !== x.sys || rst_dbg !== x.dbg || ready !== x.rdy ||
                         lock_loss_cnt !== 8'(x.llc)) begin
                errors++;
                $display("FAIL %s @edge %0d: got sys=%b dbg=%b rdy=%b cnt=%0d, want sys=%b dbg=%b rdy=%b cnt=%0d",
                         x.name, cyc, rst_sys, rst_dbg, ready, lock_loss_cnt,
                         x.sys, x.dbg, x.rdy, x.llc);
            end else begin
                $display("ok   %s @edge %0d: sys=%b dbg=%b rdy=%b cnt=%0d",
                         x.name, cyc, rst_sys, rst_dbg, ready, lock_loss_cnt);
            end
        end
        if (end_req) begin
            while (sb.size() > 0) begin
                x = sb.pop_front();
                checks++;
                errors++;
                $display("FAIL %s: expectation for edge %0d never reached (now %0d)",
                         x.name, x.cyc, cyc);
            end
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at edge %0d", cyc);
        $fatal(1, "watchdog");
    end

    int k, c, r, m, m2, k5, k6, b;

    initial begin
        srst = 1'b1; locked = 1'b0; sw_rst_req = 1'b0;

        // 1: default release timing
        expect_at(3, 1, 1, 0, 0, "t1_reset_vals");
        goto(3);
        srst = 1'b0; locked = 1'b1;
        k = cyc + 1;
        expect_at(k + 2,  1, 1, 0, 0, "t1_stable_held");
        expect_at(k + 17, 1, 1, 0, 0, "t1_dbg_hold");
        expect_at(k + 18, 1, 0, 0, 0, "t1_dbg_rel");
        expect_at(k + 21, 1, 0, 0, 0, "t1_sys_hold");
        expect_at(k + 22, 0, 0, 1, 0, "t1_run");
        goto(k + 25);

        // 2: lock dropped for 3 cycles during S_STABLE
        c = cyc;
        k = c + 3;
        expect_at(c + 1,  1, 1, 0, 0, "t2_reset_vals");
        expect_at(k + 11, 1, 1, 0, 1, "t2_loss_counted");
        expect_at(k + 12, 1, 1, 0, 1, "t2_wait");
        expect_at(k + 18, 1, 1, 0, 1, "t2_no_early_rel");
        expect_at(k + 30, 1, 1, 0, 1, "t2_dbg_hold");
        expect_at(k + 31, 1, 0, 0, 1, "t2_dbg_rel");
        expect_at(k + 34, 1, 0, 0, 1, "t2_sys_hold");
        expect_at(k + 35, 0, 0, 1, 1, "t2_run");
        srst = 1'b1; locked = 1'b0;
        goto(c + 2);
        srst = 1'b0; locked = 1'b1;
        goto(k + 9);
        locked = 1'b0;
        goto(k + 12);
        locked = 1'b1;
        goto(k + 38);

        // 3: one-cycle lock drop in S_RUN
        r = k + 40;
        expect_at(r + 1,  0, 0, 1, 2, "t3_still_run");
        expect_at(r + 2,  1, 1, 0, 2, "t3_resets_on");
        expect_at(r + 18, 1, 1, 0, 2, "t3_dbg_hold");
        expect_at(r + 19, 1, 0, 0, 2, "t3_dbg_rel");
        expect_at(r + 22, 1, 0, 0, 2, "t3_sys_hold");
        expect_at(r + 23, 0, 0, 1, 2, "t3_run");
        goto(r - 1);
        locked = 1'b0;
        goto(r);
        locked = 1'b1;
        goto(r + 25);

        // 4: single-cycle soft reset request
        m = r + 30;
        expect_at(m - 1, 0, 0, 1, 2, "t4_before");
        expect_at(m,     1, 0, 0, 2, "t4_soft_start");
        expect_at(m + 4, 1, 0, 0, 2, "t4_soft_mid");
        expect_at(m + 7, 1, 0, 0, 2, "t4_soft_last");
        expect_at(m + 8, 0, 0, 1, 2, "t4_run_again");
        goto(m - 1);
        sw_rst_req = 1'b1;
        goto(m);
        sw_rst_req = 1'b0;
        goto(m + 10);

        // 5: reset during S_SOFT, then during S_DBG_REL
        m2 = m + 12;
        k5 = m2 + 5;
        k6 = k5 + 21;
        expect_at(m2,      1, 0, 0, 2, "t5_soft");
        expect_at(m2 + 2,  1, 0, 0, 2, "t5_soft_hold");
        expect_at(m2 + 3,  1, 1, 0, 0, "t5_rst_in_soft");
        expect_at(m2 + 4,  1, 1, 0, 0, "t5_rst_held");
        expect_at(k5 + 19, 1, 0, 0, 0, "t5_dbg_rel");
        expect_at(k5 + 20, 1, 1, 0, 0, "t5_rst_in_dbgrel");
        expect_at(k6 + 21, 1, 0, 0, 0, "t5_resequence_dbg");
        expect_at(k6 + 22, 0, 0, 1, 0, "t5_resequence_run");
        goto(m2 - 1);
        sw_rst_req = 1'b1;
        goto(m2);
        sw_rst_req = 1'b0;
        goto(m2 + 2);
        srst = 1'b1;
        goto(m2 + 4);
        srst = 1'b0;
        goto(k5 + 19);
        srst = 1'b1;
        goto(k5 + 20);
        srst = 1'b0;
        goto(k6 + 25);

        // 6: 300 lock losses saturate the counter; held soft request does not extend the hold
        b = cyc + 1;
        expect_at(b + 1,           0, 0, 1, 1,   "t6_first_loss");
        expect_at(b + 5,           1, 1, 0, 2,   "t6_second_loss");
        expect_at(b + 4 * 253 + 1, 1, 1, 0, 254, "t6_cnt_254");
        expect_at(b + 4 * 254 + 1, 1, 1, 0, 255, "t6_cnt_255");
        expect_at(b + 4 * 299 + 1, 1, 1, 0, 255, "t6_saturated");
        expect_at(b + 1220,        0, 0, 1, 255, "t6_run");
        m = b + 1230;
        expect_at(m,      1, 0, 0, 255, "t6_soft_start");
        expect_at(m + 7,  1, 0, 0, 255, "t6_soft_last");
        expect_at(m + 8,  0, 0, 1, 255, "t6_hold_not_extended");
        expect_at(m + 9,  1, 0, 0, 255, "t6_soft_again");
        expect_at(m + 16, 1, 0, 0, 255, "t6_soft2_last");
        expect_at(m + 17, 0, 0, 1, 255, "t6_run2");
        expect_at(m + 19, 0, 0, 1, 255, "t6_run_stays");
        for (int i = 0; i < 300; i++) begin
            goto(b + 4 * i - 1);
            locked = 1'b0;
            goto(b + 4 * i + 1);
            locked = 1'b1;
        end
        goto(m - 1);
        sw_rst_req = 1'b1;
        goto(m + 11);
        sw_rst_req = 1'b0;
        goto(m + 22);

        end_req = 1'b1;
    end

endmodule
